// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch (I) and
// mem (D) pipeline stages. D wins ties, but a streak counter stops I from starving.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DSTARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          iready,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          dready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int SW = (DSTARVE < 1) ? 1 : $clog2(DSTARVE + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } arbState;

    arbState       stateReg, stateNext;
    logic [SW-1:0] streakReg, streakNext;

    logic          memReqReg, memReqNext;
    logic          memWeReg, memWeNext;
    logic [AW-1:0] memAddrReg, memAddrNext;
    logic [DW-1:0] memWdataReg, memWdataNext;
    logic          ireadyReg, ireadyNext;
    logic          dreadyReg, dreadyNext;
    logic [DW-1:0] irdataReg, irdataNext;
    logic [DW-1:0] drdataReg, drdataNext;

    // Every output is a flop, so reset removes an in-flight request immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            streakReg   <= '0;
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            ireadyReg   <= 1'b0;
            dreadyReg   <= 1'b0;
            irdataReg   <= '0;
            drdataReg   <= '0;
        end else begin
            stateReg    <= stateNext;
            streakReg   <= streakNext;
            memReqReg   <= memReqNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
            ireadyReg   <= ireadyNext;
            dreadyReg   <= dreadyNext;
            irdataReg   <= irdataNext;
            drdataReg   <= drdataNext;
        end
    end

    // Arbitration only happens in IDLE; requests arriving elsewhere simply wait.
    always_comb begin
        stateNext  = stateReg;
        streakNext = streakReg;
        unique case (stateReg)
            IDLE: begin
                if (dreq && !(ireq && streakReg == STREAK_MAX)) begin
                    stateNext  = DACC;
                    streakNext = ireq ? streakReg + 1'b1 : '0;
                end else if (ireq) begin
                    stateNext  = IACC;
                    streakNext = '0;
                end else begin
                    streakNext = '0;
                end
            end
            IACC, DACC: begin
                if (mem_ack) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs, keyed on the transition being taken.
    always_comb begin
        memReqNext   = memReqReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        ireadyNext   = 1'b0;
        dreadyNext   = 1'b0;
        irdataNext   = irdataReg;
        drdataNext   = drdataReg;
        if (stateReg == IDLE && stateNext == IACC) begin
            memReqNext   = 1'b1;
            memWeNext    = 1'b0;
            memAddrNext  = iaddr;
            memWdataNext = '0;
        end else if (stateReg == IDLE && stateNext == DACC) begin
            memReqNext   = 1'b1;
            memWeNext    = dwe;
            memAddrNext  = daddr;
            memWdataNext = dwdata;
        end else if ((stateReg == IACC || stateReg == DACC) && mem_ack) begin
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
            if (stateReg == IACC) begin
                ireadyNext = 1'b1;
                irdataNext = mem_rdata;
            end else begin
                dreadyNext = 1'b1;
                // A write completion keeps the last read value visible.
                if (!memWeReg) begin
                    drdataNext = mem_rdata;
                end
            end
        end
    end

    assign mem_req   = memReqReg;
    assign mem_we    = memWeReg;
    assign mem_addr  = memAddrReg;
    assign mem_wdata = memWdataReg;
    assign iready    = ireadyReg;
    assign dready    = dreadyReg;
    assign irdata    = irdataReg;
    assign drdata    = drdataReg;

endmodule
